// File: rtl/hm10_uart_rx.sv
// hm10_uart_rx: 8N1 receiver for the HM-10 TXD line feeding a show-ahead byte FIFO.
// The line is double-flopped, a start edge is confirmed at mid-bit, data bits are
// sampled at bit centres, and good bytes are pushed on the stop-sample edge.
// A low stop bit flags a framing error and parks the receiver in BREAK until the
// line returns high, so a held-low line cannot generate a stream of 0x00 bytes.
module hm10_uart_rx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 16,
  parameter int FIFO_AW      = 4
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               fpga_rxd,
  input  logic               data_read,
  input  logic               clear_errors,
  output logic [7:0]         data_out,
  output logic               data_valid,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               rx_busy,
  output logic               framing_error,
  output logic               overflow
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_ZERO    = {TW{1'b0}};
  localparam logic [TW-1:0] T_ONE     = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [FIFO_AW:0] P_ZERO = {(FIFO_AW+1){1'b0}};
  localparam logic [FIFO_AW:0] P_ONE  = {{FIFO_AW{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } rx_state_t;

  // Synchronizer, receiver and FIFO state
  logic            rxd_meta_q;
  logic            rxd_s_q;
  rx_state_t       state_q;
  logic [TW-1:0]   timer_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shreg_q;
  logic            busy_q;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0] count_q, count_d;
  logic            framing_q, framing_d;
  logic            overflow_q, overflow_d;

  // Decoded events for the current cycle
  logic stop_tick_s;
  logic empty_s;
  logic full_s;
  logic pop_s;
  logic push_s;
  logic ovf_set_s;
  logic frm_set_s;

  // Two-flop synchronizer for the asynchronous serial line, idling high
  always_ff @(posedge clock) begin
    if (!resetn) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      rxd_meta_q <= fpga_rxd;
      rxd_s_q    <= rxd_meta_q;
    end
  end

  // Receiver FSM: start validation, bit-centre sampling, stop check and break hold
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      timer_q   <= T_ZERO;
      bit_idx_q <= 3'd0;
      shreg_q   <= 8'h00;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!rxd_s_q) begin
            timer_q <= T_ZERO;
            state_q <= S_START;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (timer_q == HALF_LAST) begin
            if (!rxd_s_q) begin
              timer_q   <= T_ZERO;
              bit_idx_q <= 3'd0;
              state_q   <= S_DATA;
            end else begin
              // Start bit vanished before mid-bit: a glitch, silently ignored
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            timer_q <= timer_q + T_ONE;
          end
        end
        S_DATA: begin
          if (timer_q == BIT_LAST) begin
            timer_q <= T_ZERO;
            shreg_q <= {rxd_s_q, shreg_q[7:1]};
            if (bit_idx_q == 3'd7) begin
              state_q <= S_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            timer_q <= timer_q + T_ONE;
          end
        end
        S_STOP: begin
          if (timer_q == BIT_LAST) begin
            timer_q <= T_ZERO;
            if (rxd_s_q) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_BREAK;
            end
          end else begin
            timer_q <= timer_q + T_ONE;
          end
        end
        S_BREAK: begin
          if (rxd_s_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // FIFO control: push/pop decode, pointer and count next-state, sticky flags
  always_comb begin
    stop_tick_s = (state_q == S_STOP) && (timer_q == BIT_LAST);
    empty_s     = (wr_ptr_q == rd_ptr_q);
    full_s      = (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]) &&
                  (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]);
    pop_s       = data_read && !empty_s;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept
    push_s      = stop_tick_s && rxd_s_q && (!full_s || pop_s);
    ovf_set_s   = stop_tick_s && rxd_s_q && full_s && !pop_s;
    frm_set_s   = stop_tick_s && !rxd_s_q;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + P_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + P_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + P_ONE;
      2'b01:   count_d = count_q - P_ONE;
      default: count_d = count_q;
    endcase

    // Set beats clear when both occur together
    if (frm_set_s) begin
      framing_d = 1'b1;
    end else if (clear_errors) begin
      framing_d = 1'b0;
    end else begin
      framing_d = framing_q;
    end

    if (ovf_set_s) begin
      overflow_d = 1'b1;
    end else if (clear_errors) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // FIFO pointers, occupancy count and sticky error flags
  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr_q   <= P_ZERO;
      rd_ptr_q   <= P_ZERO;
      count_q    <= P_ZERO;
      framing_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      framing_q  <= framing_d;
      overflow_q <= overflow_d;
    end
  end

  // Byte storage; word 0 is cleared so the head reads 0x00 out of reset
  always_ff @(posedge clock) begin
    if (!resetn) begin
      mem_q[0] <= 8'h00;
    end else if (push_s) begin
      mem_q[wr_ptr_q[FIFO_AW-1:0]] <= shreg_q;
    end
  end

  assign data_out      = mem_q[rd_ptr_q[FIFO_AW-1:0]];
  assign data_valid    = !empty_s;
  assign fifo_count    = count_q;
  assign rx_busy       = busy_q;
  assign framing_error = framing_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_hm10_uart_rx.sv
// Directed bench for hm10_uart_rx: single byte, burst order, overflow, framing
// error with break, start glitch, full FIFO with simultaneous pop, mid-frame reset.
module tb_hm10_uart_rx;

  localparam int CPB = 104;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       fpga_rxd = 1'b1;
  logic       data_read = 1'b0;
  logic       clear_errors = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic [4:0] fifo_count;
  logic       rx_busy;
  logic       framing_error;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  int lat;
  logic [7:0] burst [4];

  hm10_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(16), .FIFO_AW(4)) dut (
    .clock(clock),
    .resetn(resetn),
    .fpga_rxd(fpga_rxd),
    .data_read(data_read),
    .clear_errors(clear_errors),
    .data_out(data_out),
    .data_valid(data_valid),
    .fifo_count(fifo_count),
    .rx_busy(rx_busy),
    .framing_error(framing_error),
    .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one 8N1 frame starting at the current negedge
  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    fpga_rxd = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      fpga_rxd = b[i];
      repeat (CPB) @(negedge clock);
    end
    fpga_rxd = stop_v;
    repeat (CPB) @(negedge clock);
    fpga_rxd = 1'b1;
  endtask

  task automatic pop_one();
    data_read = 1'b1;
    @(negedge clock);
    data_read = 1'b0;
  endtask

  initial begin
    burst[0] = 8'h00; burst[1] = 8'hFF; burst[2] = 8'hA5; burst[3] = 8'h3C;

    // Reset values
    repeat (3) @(negedge clock);
    chk("rst_data_out", data_out, 32'h00);
    chk("rst_valid", data_valid, 32'd0);
    chk("rst_count", fifo_count, 32'd0);
    chk("rst_busy", rx_busy, 32'd0);
    chk("rst_ferr", framing_error, 32'd0);
    chk("rst_ovf", overflow, 32'd0);
    resetn = 1'b1;
    repeat (5) @(negedge clock);

    // 1: single byte with latency bound
    fork
      send_frame(8'h5A, 1'b1);
      begin
        lat = 0;
        while (data_valid !== 1'b1 && lat < 2000) begin
          @(negedge clock);
          lat++;
        end
      end
    join
    chk("t1_latency", (lat >= 985 && lat <= 992), 32'd1);
    chk("t1_data", data_out, 32'h5A);
    chk("t1_count", fifo_count, 32'd1);
    chk("t1_busy", rx_busy, 32'd0);
    chk("t1_ferr", framing_error, 32'd0);
    chk("t1_ovf", overflow, 32'd0);
    pop_one();
    chk("t1_valid_after_pop", data_valid, 32'd0);
    chk("t1_count_after_pop", fifo_count, 32'd0);

    // 2: back-to-back burst, order and count
    for (int i = 0; i < 4; i++) send_frame(burst[i], 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("t2_count", fifo_count, 32'(4 - i));
      chk("t2_data", data_out, 32'(burst[i]));
      pop_one();
    end
    chk("t2_count_end", fifo_count, 32'd0);

    // 3: overflow on the 17th byte
    for (int i = 1; i <= 17; i++) send_frame(8'(i), 1'b1);
    chk("t3_count_full", fifo_count, 32'd16);
    chk("t3_ovf", overflow, 32'd1);
    chk("t3_ferr", framing_error, 32'd0);
    for (int i = 1; i <= 16; i++) begin
      chk("t3_data", data_out, 32'(i));
      pop_one();
    end
    chk("t3_empty", data_valid, 32'd0);
    clear_errors = 1'b1;
    @(negedge clock);
    clear_errors = 1'b0;
    chk("t3_ovf_cleared", overflow, 32'd0);

    // 4: framing error and break hold
    send_frame(8'h55, 1'b0);
    fpga_rxd = 1'b0;
    repeat (3 * CPB) @(negedge clock);
    chk("t4_ferr", framing_error, 32'd1);
    chk("t4_in_break", rx_busy, 32'd1);
    chk("t4_no_push", fifo_count, 32'd0);
    fpga_rxd = 1'b1;
    repeat (10) @(negedge clock);
    chk("t4_released", rx_busy, 32'd0);
    send_frame(8'h42, 1'b1);
    chk("t4_next_data", data_out, 32'h42);
    chk("t4_next_count", fifo_count, 32'd1);
    pop_one();
    clear_errors = 1'b1;
    @(negedge clock);
    clear_errors = 1'b0;
    chk("t4_ferr_cleared", framing_error, 32'd0);

    // 5: short glitch is rejected
    fpga_rxd = 1'b0;
    repeat (10) @(negedge clock);
    chk("t5_busy_during", rx_busy, 32'd1);
    repeat (10) @(negedge clock);
    fpga_rxd = 1'b1;
    repeat (80) @(negedge clock);
    chk("t5_idle", rx_busy, 32'd0);
    chk("t5_no_push", fifo_count, 32'd0);
    chk("t5_ferr", framing_error, 32'd0);
    chk("t5_ovf", overflow, 32'd0);

    // 6: full FIFO with pop on the stop-sample edge of a 17th byte
    for (int i = 0; i < 16; i++) send_frame(8'(8'h20 + i), 1'b1);
    chk("t6_full", fifo_count, 32'd16);
    fork
      send_frame(8'h77, 1'b1);
      begin
        repeat (990) @(negedge clock);
        data_read = 1'b1;
        @(negedge clock);
        data_read = 1'b0;
      end
    join
    chk("t6_no_ovf", overflow, 32'd0);
    chk("t6_count_16", fifo_count, 32'd16);
    for (int i = 1; i < 16; i++) begin
      chk("t6_data", data_out, 32'(8'h20 + i));
      pop_one();
    end
    chk("t6_last_77", data_out, 32'h77);
    chk("t6_last_count", fifo_count, 32'd1);

    // Mid-frame reset returns every output to its reset value
    fork
      send_frame(8'hC3, 1'b1);
      begin
        repeat (500) @(negedge clock);
        resetn = 1'b0;
        repeat (2) @(negedge clock);
        chk("t6r_data_out", data_out, 32'h00);
        chk("t6r_valid", data_valid, 32'd0);
        chk("t6r_count", fifo_count, 32'd0);
        chk("t6r_busy", rx_busy, 32'd0);
        chk("t6r_ferr", framing_error, 32'd0);
        chk("t6r_ovf", overflow, 32'd0);
        resetn = 1'b1;
      end
    join
    repeat (12 * CPB) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hm10_uart_rx.md
# hm10_uart_rx

Receive half of the HM-10 serial link: deserializes the 8N1 byte stream that the HM-10 drives on its TXD pin (`fpga_rxd` inside `FPGA_Bluetooth_connection`) and buffers the bytes in a small show-ahead FIFO. Host-side logic pops bytes from the FIFO for delivery to Opal Kelly wireOuts. It is the counterpart of the existing FPGA transmit path on `fpga_txd`. It runs on the 1 MHz board clock.

## Interface

Parameters:
- `CLKS_PER_BIT`, 104 — clock cycles per UART bit (1 MHz / 9600 baud); must be ≥ 8.
- `FIFO_DEPTH`, 16 — byte FIFO depth; must be a power of two, ≥ 2.
- `FIFO_AW`, 4 — log2(`FIFO_DEPTH`).

Ports:
- `clock` input 1 — system clock, 1 MHz.
- `resetn` input 1 — reset. One clock; reset is synchronous and active-low.
- `fpga_rxd` input 1 — asynchronous serial line from HM-10 TXD; idles high.
- `data_read` input 1 — pop request; honoured only when `data_valid`=1.
- `clear_errors` input 1 — synchronous clear of the sticky error flags.
- `data_out` output 8 — FIFO head byte; valid when `data_valid`=1.
- `data_valid` output 1 — FIFO not empty.
- `fifo_count` output `FIFO_AW`+1 — bytes currently held, 0..`FIFO_DEPTH`.
- `rx_busy` output 1 — high in any receiver state except IDLE.
- `framing_error` output 1 — sticky; set when a stop bit is sampled low.
- `overflow` output 1 — sticky; set when a received byte is dropped because the FIFO is full.

## Operation

- **Input synchronizer:** `fpga_rxd` passes through 2 flops, both reset to 1. All decisions use the second-stage value `rxd_s`.
- **Receiver FSM** uses a bit-timer counter, a 3-bit bit index, and an 8-bit shift register.
  - IDLE: when `rxd_s`=0, clear the timer and go to START.
  - START: when the timer reaches `CLKS_PER_BIT/2 - 1`, sample `rxd_s`. If 0, clear the timer and bit index and go to DATA. If 1, treat it as a glitch and return to IDLE; no error is flagged.
  - DATA: every `CLKS_PER_BIT` cycles, sample `rxd_s` into the shift register MSB while shifting right (LSB first on the wire). After bit index 7, go to STOP.
  - STOP: after `CLKS_PER_BIT` cycles, sample `rxd_s`.
    - If 1: push the byte and go to IDLE.
    - If 0: set `framing_error`, discard the byte, and go to BREAK.
  - BREAK: stay until `rxd_s`=1, then go to IDLE. This prevents a held-low line from producing repeated 0x00 bytes.
- **FIFO:**
  - `FIFO_DEPTH` × 8 memory, with `FIFO_AW`+1-bit read and write pointers.
  - Empty when the pointers are equal. Full when the low bits are equal and the MSBs differ.
  - Show-ahead: `data_out` = mem[rd_ptr[`FIFO_AW`-1:0]].
  - Pop occurs when `data_read` && !empty. `data_read` while empty is ignored.
  - Push occurs when the STOP sample is good and (!full or a pop happens in the same cycle).
  - A good byte that arrives while full with no pop is dropped and sets `overflow`.
  - Simultaneous push and pop: `fifo_count` is unchanged and both pointers advance.
  - Pointers wrap naturally modulo 2·`FIFO_DEPTH`.
- **Error flags:** set and clear are both synchronous. If `clear_errors` and a set event happen in the same cycle, set wins.
- **Reset:** a mid-frame reset aborts the frame; the partial byte is lost and the FIFO contents are lost.

## Timing

- **Reset values:** FSM IDLE; `data_out`=0x00 (memory word 0 is also cleared); `data_valid`=0; `fifo_count`=0; `rx_busy`=0; `framing_error`=0; `overflow`=0; synchronizer flops =1.
- **Start-edge latency:** a pin falling edge reaches `rxd_s` 2 cycles later. `rx_busy` rises on the following cycle.
- **Sample points:** the start bit is checked at about `CLKS_PER_BIT/2` cycles after edge detection. Data bit n is sampled at about `CLKS_PER_BIT/2 + (n+1)·CLKS_PER_BIT`, and the stop bit at about `CLKS_PER_BIT/2 + 9·CLKS_PER_BIT`. Tolerance is ±1 cycle.
- **Push latency:** the push takes effect on the clock edge that samples the stop bit. `data_valid` and `fifo_count` update on the next cycle, and `rx_busy` falls the same cycle.
- **Pop:** the next byte, or `data_valid`=0, appears the cycle after `data_read`. Back-to-back pops every cycle are supported.
- **Back-to-back frames:** a new start edge is accepted the first cycle after returning to IDLE. No extra idle bit time is required.

## Test plan

1. **Single byte:** reset, then send 0x5A at 104 clk/bit. Required: `data_valid`=1 and `data_out`=0x5A within 9.5 bit times + 4 cycles of the falling edge; `fifo_count`=1; no error flags. Pulse `data_read`: `data_valid`=0 and `fifo_count`=0 next cycle.
2. **Burst and order:** send 0x00, 0xFF, 0xA5, 0x3C back-to-back. Then pop four times. Required: bytes come out in that order; `fifo_count` reads 4, 3, 2, 1, 0.
3. **Overflow:** send 17 bytes 0x01..0x11 with no pops. Required: `fifo_count`=16 and `overflow`=1; pops yield 0x01..0x10; 0x11 is lost. `clear_errors` then clears `overflow`.
4. **Framing error:** send 0x55 with the stop bit held low, then hold the line low for 3 bit times, then release it. Required: `framing_error`=1; nothing pushed; FSM stays in BREAK until release. A following 0x42 is received correctly.
5. **Glitch:** drive a 20-cycle low pulse on `fpga_rxd`. Required: the FSM returns to IDLE; no push; no error flags.
6. **Full with simultaneous pop:** fill the FIFO to 16, then pulse `data_read` on the stop-sample cycle of a 17th byte 0x77. Required: no overflow; `fifo_count` stays 16; 0x77 is last out. Then assert reset mid-frame: all outputs return to their reset values.
